// File: rtl/mux_4x1_rr_pkg.sv
// mux_4x1_rr_pkg: shared FSM states and channel index encodings for the collector and its demux tree.
//   ST_EMPTY/ST_FULL : output register state
//   CH1..CH4         : 2-bit channel index, 00 -> channel 1 ... 11 -> channel 4
package mux_4x1_rr_pkg;
    typedef enum logic {ST_EMPTY = 1'b0, ST_FULL = 1'b1} state_e;
    localparam logic [1:0] CH1 = 2'b00;
    localparam logic [1:0] CH2 = 2'b01;
    localparam logic [1:0] CH3 = 2'b10;
    localparam logic [1:0] CH4 = 2'b11;
endpackage

// File: rtl/rr_arbiter_4.sv
// rr_arbiter_4: combinational 4-way round-robin arbiter.
//   Req[3:0]      : per-channel requests (bit 0 = channel 1)
//   Last[1:0]     : index of the most recently granted channel
//   Grant[3:0]    : one-hot grant, zero when nothing requests
//   GrantIdx[1:0] : index of the granted channel
//   Any           : at least one request present
module rr_arbiter_4 (
    input  logic [3:0] Req,
    input  logic [1:0] Last,
    output logic [3:0] Grant,
    output logic [1:0] GrantIdx,
    output logic       Any
);
    assign Any = |Req;
    // Scan from furthest to nearest so the first requester after Last wins;
    // offset 4 wraps to Last itself, reached only when it is the sole requester.
    always_comb begin
        GrantIdx = Last;
        for (int k = 4; k >= 1; k--)
            if (Req[Last + 2'(k)]) GrantIdx = Last + 2'(k);
        Grant = Any ? 4'b0001 << GrantIdx : 4'b0000;
    end
endmodule

// File: rtl/mux_4x1_rr.sv
// mux_4x1_rr: four-channel round-robin collector with a registered valid/ready output stage.
//   Clk, Reset         : clock, synchronous active-high reset
//   Req[3:0]           : per-channel requests (bit 0 = channel 1)
//   Data1..Data4[W-1:0]: channel payloads
//   Ack[3:0]           : combinational one-hot grant, high in the capture cycle
//   Out[W-1:0]         : registered selected payload
//   OutValid, OutReady : output handshake
//   Sel[1:0]           : registered channel index of Out
module mux_4x1_rr
    import mux_4x1_rr_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic [3:0]   Req,
    input  logic [W-1:0] Data1,
    input  logic [W-1:0] Data2,
    input  logic [W-1:0] Data3,
    input  logic [W-1:0] Data4,
    output logic [3:0]   Ack,
    output logic [W-1:0] Out,
    output logic         OutValid,
    input  logic         OutReady,
    output logic [1:0]   Sel
);
    state_e         state_q, state_d;
    logic [1:0]     last_q, last_d, sel_q, sel_d, idx;
    logic [W-1:0]   out_q, out_d, data_sel;
    logic [3:0]     grant;
    logic           any, load;

    rr_arbiter_4 u_arb (
        .Req      (Req),
        .Last     (last_q),
        .Grant    (grant),
        .GrantIdx (idx),
        .Any      (any)
    );

    assign data_sel = idx == CH1 ? Data1 : idx == CH2 ? Data2 : idx == CH3 ? Data3 : Data4;
    // OutReady only matters when FULL, so accept and reload share one edge.
    assign load     = state_q == ST_EMPTY || OutReady;

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        sel_d   = sel_q;
        out_d   = out_q;
        Ack     = 4'b0000;
        if (load && !Reset) begin
            Ack     = grant;
            state_d = any ? ST_FULL : ST_EMPTY;
            last_d  = any ? idx : last_q;
            sel_d   = any ? idx : sel_q;
            out_d   = any ? data_sel : out_q;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= ST_EMPTY;
            last_q  <= CH4;
            sel_q   <= CH1;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            sel_q   <= sel_d;
            out_q   <= out_d;
        end
    end

    assign Out      = out_q;
    assign Sel      = sel_q;
    assign OutValid = state_q == ST_FULL;
endmodule

// File: tb/tb_mux_4x1_rr.sv
// tb_mux_4x1_rr: scoreboard bench for mux_4x1_rr with directed and random stimulus.
module tb_mux_4x1_rr;
    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic       OutReady = 1'b1;
    logic [3:0] Req = 4'b1111;
    logic [7:0] d[4];
    logic [3:0] Ack;
    logic [7:0] Out;
    logic       OutValid;
    logic [1:0] Sel;

    mux_4x1_rr #(.W(8)) dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .Req      (Req),
        .Data1    (d[0]),
        .Data2    (d[1]),
        .Data3    (d[2]),
        .Data4    (d[3]),
        .Ack      (Ack),
        .Out      (Out),
        .OutValid (OutValid),
        .OutReady (OutReady),
        .Sel      (Sel)
    );

    always #5 Clk = ~Clk;

    int         errors = 0;
    int         checks = 0;
    bit         m_init = 0;
    bit         m_full = 0;
    int         m_last = 4;
    logic [7:0] m_out = '0;
    logic [1:0] m_sel = '0;
    logic [3:0] exp_ack = '0;
    logic [3:0] e;
    int         g, c;
    logic [9:0] sb[$];
    logic [9:0] w;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: channels numbered 1..4, grant = first requester after the last winner.
    always @(negedge Clk) begin
        if (m_init) begin
            chk("out_valid", OutValid, m_full);
            chk("out", Out, m_out);
            chk("sel", Sel, m_sel);
        end
        e = 4'b0000;
        if (Reset) begin
            m_init = 1;
            m_full = 0;
            m_last = 4;
            m_out  = '0;
            m_sel  = '0;
            sb.delete();
        end else if (m_init && (!m_full || OutReady)) begin
            g = 0;
            for (int k = 1; k <= 4 && g == 0; k++) begin
                c = (m_last + k - 1) % 4 + 1;
                if (Req[c-1]) g = c;
            end
            if (g != 0) begin
                e = 4'(1 << (g - 1));
                sb.push_back({d[g-1], 2'(g - 1)});
                m_out  = d[g-1];
                m_sel  = 2'(g - 1);
                m_last = g;
                m_full = 1;
            end else begin
                m_full = 0;
            end
        end
        chk("ack", Ack, e);
        exp_ack = e;
    end

    always @(negedge Clk) begin
        if (!Reset && OutValid === 1'b1 && OutReady) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL accept: word Out=%0h Sel=%0d presented with no expected word queued", Out, Sel);
            end else begin
                w = sb.pop_front();
                chk("accept_out", Out, w[9:2]);
                chk("accept_sel", Sel, w[1:0]);
            end
        end
    end

    task automatic step(input logic [3:0] r, input logic rd, input int n);
        repeat (n) begin
            Req = r;
            OutReady = rd;
            @(posedge Clk);
            #1;
        end
    endtask

    initial begin
        d = '{8'h11, 8'h22, 8'h33, 8'h44};
        repeat (2) @(posedge Clk);
        #1 Reset = 1'b0;
        step(4'b1111, 1'b1, 9);
        step(4'b0000, 1'b1, 1);
        d[2] = 8'hA5;
        step(4'b0100, 1'b1, 1);
        step(4'b1011, 1'b0, 5);
        step(4'b1011, 1'b1, 2);
        step(4'b0000, 1'b1, 2);
        step(4'b0001, 1'b1, 1);
        step(4'b1001, 1'b1, 2);
        step(4'b0000, 1'b1, 2);
        d[1] = 8'h22;
        step(4'b0010, 1'b1, 1);
        step(4'b0000, 1'b1, 3);
        step(4'b0100, 1'b0, 2);
        Reset = 1'b1;
        step(4'b1010, 1'b0, 1);
        Reset = 1'b0;
        step(4'b1010, 1'b1, 2);
        step(4'b0000, 1'b1, 2);
        // Random traffic: a channel may change only when idle or just acknowledged.
        repeat (3000) begin
            for (int i = 0; i < 4; i++)
                if (!Req[i] || exp_ack[i]) begin
                    Req[i] = ($urandom % 3) != 0;
                    d[i] = 8'($urandom);
                end
            OutReady = ($urandom % 4) != 0;
            @(posedge Clk);
            #1;
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
